// File: rtl/axi_arbiter.sv
// axi_arbiter: shares one AXI3 master port between an instruction-read,
// a data-read and a data-write requester. Reads and writes run on separate
// FSMs; data reads wait for an idle write side, and writes wait while a data
// read is returning beats.
module axi_arbiter (
  input  logic        clock,
  input  logic        reset,
  // instruction read requester
  input  logic        inst_rd_req,
  input  logic [31:0] inst_rd_addr,
  input  logic [7:0]  inst_rd_len,
  output logic        inst_rd_gnt,
  output logic        inst_ret_valid,
  output logic        inst_ret_last,
  output logic [31:0] inst_ret_data,
  // data read requester
  input  logic        data_rd_req,
  input  logic [31:0] data_rd_addr,
  input  logic [7:0]  data_rd_len,
  input  logic [2:0]  data_rd_size,
  output logic        data_rd_gnt,
  output logic        data_ret_valid,
  output logic        data_ret_last,
  output logic [31:0] data_ret_data,
  // data write requester
  input  logic        data_wr_req,
  input  logic [31:0] data_wr_addr,
  input  logic [7:0]  data_wr_len,
  input  logic [2:0]  data_wr_size,
  input  logic [3:0]  data_wr_strb,
  input  logic [31:0] data_wr_data,
  output logic        data_wr_gnt,
  output logic        data_wr_dready,
  output logic        data_wr_done,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [1:0]  r_state_q, r_state_d;
  logic        r_id_q, r_id_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [7:0]  r_len_q, r_len_d;
  logic [2:0]  r_size_q, r_size_d;

  logic [1:0]  w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [7:0]  w_cnt_q, w_cnt_d;

  // Response codes and the write-response id carry no information we act on.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp, bid};

  // Read side: arbitrate in idle, then address phase, then collect beats.
  always_comb begin
    r_state_d   = r_state_q;
    r_id_d      = r_id_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_size_d    = r_size_q;
    inst_rd_gnt = 1'b0;
    data_rd_gnt = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        // Grants are combinational, so they are held off during reset.
        if (!reset) begin
          if (data_rd_req && (w_state_q == W_IDLE)) begin
            data_rd_gnt = 1'b1;
            r_id_d      = 1'b1;
            r_addr_d    = data_rd_addr;
            r_len_d     = data_rd_len;
            r_size_d    = data_rd_size;
            r_state_d   = R_AR;
          end else if (inst_rd_req) begin
            inst_rd_gnt = 1'b1;
            r_id_d      = 1'b0;
            r_addr_d    = inst_rd_addr;
            r_len_d     = inst_rd_len;
            r_size_d    = 3'd2;
            r_state_d   = R_AR;
          end
        end
      end
      R_AR: begin
        if (arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid && rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write side: arbitrate in idle, address phase, data beats, then response.
  always_comb begin
    w_state_d    = w_state_q;
    w_addr_d     = w_addr_q;
    w_len_d      = w_len_q;
    w_size_d     = w_size_q;
    w_cnt_d      = w_cnt_q;
    data_wr_gnt  = 1'b0;
    data_wr_done = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (!reset && data_wr_req && !((r_state_q == R_DATA) && r_id_q)) begin
          data_wr_gnt = 1'b1;
          w_addr_d    = data_wr_addr;
          w_len_d     = data_wr_len;
          w_size_d    = data_wr_size;
          w_state_d   = W_AW;
        end
      end
      W_AW: begin
        if (awready) begin
          w_cnt_d   = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wready) begin
          w_cnt_d = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          data_wr_done = 1'b1;
          w_state_d    = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // State and latched request fields; reset aborts any transfer in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= 1'b0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  assign arid    = {3'b000, r_id_q};
  assign araddr  = r_addr_q;
  assign arlen   = r_len_q;
  assign arsize  = r_size_q;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_DATA);

  // Beats are steered by rid; anything other than id 0 belongs to data.
  assign inst_ret_valid = rvalid && rready && (rid == 4'd0);
  assign data_ret_valid = rvalid && rready && (rid != 4'd0);
  assign inst_ret_last  = rlast;
  assign data_ret_last  = rlast;
  assign inst_ret_data  = rdata;
  assign data_ret_data  = rdata;

  assign awid    = 4'd1;
  assign awaddr  = w_addr_q;
  assign awlen   = w_len_q;
  assign awsize  = w_size_q;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = (w_state_q == W_AW);

  assign wid            = 4'd1;
  assign wdata          = data_wr_data;
  assign wstrb          = data_wr_strb;
  assign wvalid         = (w_state_q == W_DATA);
  assign wlast          = wvalid && (w_cnt_q == w_len_q);
  assign data_wr_dready = wvalid && wready;
  assign bready         = (w_state_q == W_RESP);

endmodule
